// File: rtl/in_unit.sv
// MIX input unit: receives 8N1 characters, packs 6-bit bytes into 30-bit words, stores a block.
// Store follows the 5th byte by one cycle; stop follows the final store by one cycle.
module in_unit #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORDS        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] addressin,
  input  logic        rx,
  output logic [11:0] addressout,
  output logic [29:0] out,
  output logic        store,
  output logic        busy,
  output logic        stop,
  output logic        frame_err
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] FULL_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  logic            rx_meta, rx_sync;
  rx_state_t       state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            stop_tick, byte_valid, frame_bad;
  logic [5:0]      rx_byte;

  logic [11:0]     base;
  logic [3:0]      idx;
  logic [2:0]      cnt;
  logic [29:0]     word_sh;
  logic            final_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Stop-bit sample produces the byte strobe in the same cycle.
  assign stop_tick  = (state == STOP) && (timer == FULL_TICK);
  assign byte_valid = stop_tick && rx_sync;
  assign frame_bad  = stop_tick && !rx_sync;
  assign rx_byte    = shreg[5:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (timer == HALF_TICK) begin
            timer <= '0;
            state <= rx_sync ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == FULL_TICK) begin
            timer   <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == FULL_TICK) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base       <= '0;
      idx        <= '0;
      cnt        <= '0;
      word_sh    <= '0;
      final_word <= 1'b0;
      busy       <= 1'b0;
      store      <= 1'b0;
      stop       <= 1'b0;
      frame_err  <= 1'b0;
      out        <= '0;
      addressout <= '0;
    end else begin
      store <= 1'b0;
      stop  <= 1'b0;
      if (start && !busy) begin
        base      <= addressin;
        idx       <= '0;
        cnt       <= '0;
        word_sh   <= '0;
        frame_err <= 1'b0;
        busy      <= 1'b1;
      end else if (byte_valid && busy) begin
        word_sh <= {word_sh[23:0], rx_byte};
        if (cnt == 3'd4) begin
          store      <= 1'b1;
          out        <= {word_sh[23:0], rx_byte};
          addressout <= base + {8'd0, idx};
          cnt        <= '0;
          idx        <= idx + 1'b1;
          final_word <= (idx == LAST_IDX);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // Completion: busy drops in the same cycle stop is raised.
      if (store && final_word) begin
        stop <= 1'b1;
        busy <= 1'b0;
      end
      if (frame_bad) frame_err <= 1'b1;
    end
  end

endmodule
